nic_fifo_channel: RTL and testbench

Parametrised network interface controller between one PE (CPU) and its mesh router port. It replaces single-entry channel buffers with DEPTH-entry input and output FIFOs and uses explicit valid/count tracking, so an all-zero packet is legal. Injection is gated by router ready and by virtual-channel polarity. The CPU side adds status words carrying count and sticky overflow, and pop-on-read semantics.

---
 rtl/nic_pkg.sv | 16 +
 rtl/nic_sync_fifo.sv | 60 ++++++
 rtl/nic_fifo_channel.sv | 114 +++++++++++
 tb/tb_nic_fifo_channel.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nic_pkg.sv
// Shared constants for the NIC FIFO channel: CPU register map, status word layout, VC bit.
package nic_pkg;

  localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  // Status positions are offsets back from the last packet index (PACKET_WIDTH-ofs).
  localparam int STAT_FLAG0_OFS = 1;
  localparam int STAT_FLAG1_OFS = 2;
  localparam int STAT_CNT_OFS   = 3;

  localparam int VC_BIT = 0;

endpackage

// File: rtl/nic_sync_fifo.sv
// Synchronous FIFO with explicit occupancy count, so a stored all-zero packet stays visible.
module nic_sync_fifo
  import nic_pkg::*;
#(
  parameter int PACKET_WIDTH = 64,
  parameter int DEPTH        = 4,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [0:PACKET_WIDTH-1] din,
  output logic [0:PACKET_WIDTH-1] head,
  output logic                    full,
  output logic                    empty,
  output logic [CNT_W-1:0]        count
);

  logic [0:PACKET_WIDTH-1] mem_r [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic                    do_push_s;
  logic                    do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/nic_fifo_channel.sv
// NIC between a CPU and its mesh router port: router->CPU input FIFO, CPU->router output
// FIFO with VC-polarity-gated injection, and status words with sticky output overflow.
module nic_fifo_channel
  import nic_pkg::*;
#(
  parameter int PACKET_WIDTH = 64,
  parameter int DEPTH        = 4,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              addr,
  input  logic [0:PACKET_WIDTH-1] d_in,
  output logic [0:PACKET_WIDTH-1] d_out,
  input  logic                    nicEn,
  input  logic                    nicEnWR,
  input  logic                    net_si,
  output logic                    net_ri,
  input  logic [0:PACKET_WIDTH-1] net_di,
  output logic                    net_so,
  input  logic                    net_ro,
  output logic [0:PACKET_WIDTH-1] net_do,
  input  logic                    net_polarity
);

  logic                    cpu_rd_s, cpu_wr_s;
  logic                    in_push_s, in_pop_s, in_full_s, in_empty_s;
  logic                    out_push_s, out_full_s, out_empty_s;
  logic                    inject_s, ovf_set_s;
  logic [CNT_W-1:0]        in_count_s, out_count_s;
  logic [0:PACKET_WIDTH-1] in_head_s, out_head_s, in_stat_s, out_stat_s;
  logic [0:PACKET_WIDTH-1] d_out_r, net_do_r;
  logic                    net_so_r, ovf_r;

  assign cpu_rd_s   = nicEn & ~nicEnWR;
  assign cpu_wr_s   = nicEn & nicEnWR;
  assign net_ri     = ~in_full_s;
  assign in_push_s  = net_si & ~in_full_s;
  assign in_pop_s   = cpu_rd_s & (addr == ADDR_IN_DATA) & ~in_empty_s;
  assign out_push_s = cpu_wr_s & (addr == ADDR_OUT_DATA) & ~out_full_s;
  assign ovf_set_s  = cpu_wr_s & (addr == ADDR_OUT_DATA) & out_full_s;
  // The !net_so_r term spaces injections at least two cycles apart.
  assign inject_s   = ~out_empty_s & net_ro & (out_head_s[VC_BIT] == net_polarity) & ~net_so_r;

  assign d_out  = d_out_r;
  assign net_so = net_so_r;
  assign net_do = net_do_r;

  nic_sync_fifo #(.PACKET_WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk(clk), .reset(reset), .push(in_push_s), .pop(in_pop_s), .din(net_di),
    .head(in_head_s), .full(in_full_s), .empty(in_empty_s), .count(in_count_s)
  );

  nic_sync_fifo #(.PACKET_WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk(clk), .reset(reset), .push(out_push_s), .pop(inject_s), .din(d_in),
    .head(out_head_s), .full(out_full_s), .empty(out_empty_s), .count(out_count_s)
  );

  // Status word assembly for both channels.
  always_comb begin
    in_stat_s  = '0;
    out_stat_s = '0;
    in_stat_s[PACKET_WIDTH-STAT_FLAG0_OFS] = ~in_empty_s;
    in_stat_s[PACKET_WIDTH-STAT_CNT_OFS-CNT_W+1 : PACKET_WIDTH-STAT_CNT_OFS] = in_count_s;
    out_stat_s[PACKET_WIDTH-STAT_FLAG0_OFS] = out_full_s;
    out_stat_s[PACKET_WIDTH-STAT_FLAG1_OFS] = ovf_r;
    out_stat_s[PACKET_WIDTH-STAT_CNT_OFS-CNT_W+1 : PACKET_WIDTH-STAT_CNT_OFS] = out_count_s;
  end

  // CPU read data register; holds when no read is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out_r <= '0;
    end else if (cpu_rd_s) begin
      case (addr)
        ADDR_IN_DATA:  d_out_r <= in_empty_s ? {PACKET_WIDTH{1'b0}} : in_head_s;
        ADDR_IN_STAT:  d_out_r <= in_stat_s;
        ADDR_OUT_DATA: d_out_r <= out_empty_s ? {PACKET_WIDTH{1'b0}} : out_head_s;
        ADDR_OUT_STAT: d_out_r <= out_stat_s;
        default:       d_out_r <= d_out_r;
      endcase
    end else begin
      d_out_r <= d_out_r;
    end
  end

  // Sticky overflow: a new overflow beats the clear-on-read of the output status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (cpu_rd_s && (addr == ADDR_OUT_STAT)) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Router injection: one-cycle send strobe, net_do keeps the last packet sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      net_so_r <= 1'b0;
      net_do_r <= '0;
    end else if (inject_s) begin
      net_so_r <= 1'b1;
      net_do_r <= out_head_s;
    end else begin
      net_so_r <= 1'b0;
      net_do_r <= net_do_r;
    end
  end

endmodule

// File: tb/tb_nic_fifo_channel.sv
// Bench for nic_fifo_channel: queue-based reference model checked every cycle,
// plus hand-computed expectations at key points of each directed scenario.
module tb_nic_fifo_channel;

  localparam int PW    = 64;
  localparam int DEPTH = 4;
  typedef logic [0:PW-1] pkt_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] addr = 2'b00;
  pkt_t       d_in = '0;
  pkt_t       d_out;
  logic       nicEn = 1'b0;
  logic       nicEnWR = 1'b0;
  logic       net_si = 1'b0;
  logic       net_ri;
  pkt_t       net_di = '0;
  logic       net_so;
  logic       net_ro = 1'b0;
  pkt_t       net_do;
  logic       net_polarity = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  nic_fifo_channel #(.PACKET_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicEnWR(nicEnWR), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two packet queues, a sticky flag and the registered outputs.
  pkt_t m_in_q[$];
  pkt_t m_out_q[$];
  bit   m_ovf = 1'b0;
  pkt_t m_dout = '0;
  bit   m_so = 1'b0;
  pkt_t m_do = '0;
  bit   m_rd, m_wr, m_in_full, m_out_full, m_inj;

  function automatic pkt_t stat_word(input int cnt, input bit b1, input bit b0);
    return {59'd0, 3'(cnt), b1, b0};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_in_q.delete();
      m_out_q.delete();
      m_ovf  = 1'b0;
      m_dout = '0;
      m_so   = 1'b0;
      m_do   = '0;
    end else begin
      m_rd       = nicEn && !nicEnWR;
      m_wr       = nicEn && nicEnWR;
      m_in_full  = (m_in_q.size() == DEPTH);
      m_out_full = (m_out_q.size() == DEPTH);
      m_inj      = (m_out_q.size() > 0) && net_ro && (m_out_q[0][0] == net_polarity) && !m_so;
      if (m_rd) begin
        case (addr)
          2'd0:    m_dout = (m_in_q.size() > 0) ? m_in_q[0] : '0;
          2'd1:    m_dout = stat_word(m_in_q.size(), 1'b0, m_in_q.size() > 0);
          2'd2:    m_dout = (m_out_q.size() > 0) ? m_out_q[0] : '0;
          default: m_dout = stat_word(m_out_q.size(), m_ovf, m_out_full);
        endcase
      end
      if (m_wr && addr == 2'd2 && m_out_full) m_ovf = 1'b1;
      else if (m_rd && addr == 2'd3) m_ovf = 1'b0;
      if (m_inj) begin
        m_so = 1'b1;
        m_do = m_out_q[0];
      end else begin
        m_so = 1'b0;
      end
      if (m_rd && addr == 2'd0 && m_in_q.size() > 0) void'(m_in_q.pop_front());
      if (net_si && !m_in_full) m_in_q.push_back(net_di);
      if (m_inj) void'(m_out_q.pop_front());
      if (m_wr && addr == 2'd2 && !m_out_full) m_out_q.push_back(d_in);
    end
  end

  // Per-cycle comparison, mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("cyc_d_out", d_out, m_dout);
      check("cyc_net_ri", {63'd0, net_ri}, {63'd0, m_in_q.size() != DEPTH});
      check("cyc_net_so", {63'd0, net_so}, {63'd0, m_so});
      check("cyc_net_do", net_do, m_do);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_rd(input logic [1:0] a);
    nicEn = 1'b1; nicEnWR = 1'b0; addr = a;
    cyc();
    nicEn = 1'b0;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input pkt_t d);
    nicEn = 1'b1; nicEnWR = 1'b1; addr = a; d_in = d;
    cyc();
    nicEn = 1'b0; nicEnWR = 1'b0;
  endtask

  task automatic rt_push(input pkt_t d);
    net_si = 1'b1; net_di = d;
    cyc();
    net_si = 1'b0;
  endtask

  pkt_t pk;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_d_out", d_out, 64'h0);
    check("rst_net_ri", {63'd0, net_ri}, 64'h1);
    check("rst_net_so", {63'd0, net_so}, 64'h0);
    check("rst_net_do", net_do, 64'h0);

    // Zero packet is a real entry.
    rt_push(64'h0);
    check("zero_net_ri", {63'd0, net_ri}, 64'h1);
    cpu_rd(2'b01);
    check("zero_in_stat", d_out, 64'h5);
    cpu_rd(2'b00);
    check("zero_in_data", d_out, 64'h0);
    cpu_rd(2'b01);
    check("zero_in_stat_after", d_out, 64'h0);

    // Fill input FIFO, blocked 5th push concurrent with a CPU pop.
    for (int i = 1; i <= 4; i++) begin
      pk = 64'h1111_0000_0000_0000 | 64'(i);
      rt_push(pk);
    end
    check("full_net_ri", {63'd0, net_ri}, 64'h0);
    net_si = 1'b1; net_di = 64'hDEAD_BEEF_0000_0005;
    nicEn = 1'b1; nicEnWR = 1'b0; addr = 2'b00;
    cyc();
    net_si = 1'b0; nicEn = 1'b0;
    check("pop_full_data", d_out, 64'h1111_0000_0000_0001);
    check("pop_full_net_ri", {63'd0, net_ri}, 64'h1);
    cpu_rd(2'b00); check("in_order2", d_out, 64'h1111_0000_0000_0002);
    cpu_rd(2'b00); check("in_order3", d_out, 64'h1111_0000_0000_0003);
    cpu_rd(2'b00); check("in_order4", d_out, 64'h1111_0000_0000_0004);
    cpu_rd(2'b00); check("in_empty_read", d_out, 64'h0);

    // Output overflow and clear-on-read.
    for (int i = 1; i <= 5; i++) begin
      pk = 64'h0B00_0000_0000_0000 | 64'(i);
      cpu_wr(2'b10, pk);
    end
    cpu_rd(2'b11); check("out_stat_ovf", d_out, 64'h13);
    cpu_rd(2'b11); check("out_stat_clr", d_out, 64'h11);
    cpu_rd(2'b10); check("out_head", d_out, 64'h0B00_0000_0000_0001);
    cpu_rd(2'b10); check("out_head_nopop", d_out, 64'h0B00_0000_0000_0001);
    cpu_wr(2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
    cpu_wr(2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
    cpu_rd(2'b01); check("ignored_wr_in", d_out, 64'h0);
    cpu_rd(2'b11); check("ignored_wr_out", d_out, 64'h11);
    net_polarity = 1'b0; net_ro = 1'b1;
    repeat (8) cyc();
    net_ro = 1'b0;
    check("drain_net_do", net_do, 64'h0B00_0000_0000_0004);
    cpu_rd(2'b11); check("drain_out_stat", d_out, 64'h0);

    // Alternating injection with a concurrent CPU write.
    cpu_wr(2'b10, 64'h0C00_0000_0000_0001);
    net_ro = 1'b1;
    nicEn = 1'b1; nicEnWR = 1'b1; addr = 2'b10; d_in = 64'h0C00_0000_0000_0002;
    cyc();
    nicEn = 1'b0; nicEnWR = 1'b0;
    check("alt_so1", {63'd0, net_so}, 64'h1);
    check("alt_do1", net_do, 64'h0C00_0000_0000_0001);
    cyc(); check("alt_gap", {63'd0, net_so}, 64'h0);
    cyc();
    check("alt_so2", {63'd0, net_so}, 64'h1);
    check("alt_do2", net_do, 64'h0C00_0000_0000_0002);
    cyc();
    check("alt_end", {63'd0, net_so}, 64'h0);
    check("alt_hold", net_do, 64'h0C00_0000_0000_0002);
    net_ro = 1'b0;

    // VC polarity gating.
    cpu_wr(2'b10, 64'h8000_0000_0000_00AB);
    net_ro = 1'b1; net_polarity = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("vc_wait", {63'd0, net_so}, 64'h0);
    end
    net_polarity = 1'b1;
    cyc();
    check("vc_go_so", {63'd0, net_so}, 64'h1);
    check("vc_go_do", net_do, 64'h8000_0000_0000_00AB);
    cyc();
    check("vc_pulse_end", {63'd0, net_so}, 64'h0);
    net_ro = 1'b0; net_polarity = 1'b0;

    // Asynchronous reset mid-transfer.
    cpu_wr(2'b10, 64'h0E00_0000_0000_0001);
    cpu_wr(2'b10, 64'h0E00_0000_0000_0002);
    rt_push(64'h0F00_0000_0000_0001);
    rt_push(64'h0F00_0000_0000_0002);
    cpu_rd(2'b01); check("pre_rst_in_stat", d_out, 64'h9);
    net_ro = 1'b1;
    cyc();
    check("pre_rst_so", {63'd0, net_so}, 64'h1);
    #1 reset = 1'b1;
    #1;
    check("arst_net_so", {63'd0, net_so}, 64'h0);
    check("arst_d_out", d_out, 64'h0);
    check("arst_net_ri", {63'd0, net_ri}, 64'h1);
    check("arst_net_do", net_do, 64'h0);
    net_ro = 1'b0;
    cyc();
    reset = 1'b0;
    cpu_rd(2'b01); check("post_rst_in_stat", d_out, 64'h0);
    cpu_rd(2'b11); check("post_rst_out_stat", d_out, 64'h0);
    cpu_rd(2'b00); check("post_rst_in_data", d_out, 64'h0);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
